// File: rtl/pass_entry_encoder.sv
// Keypad digit collector: packs up to four BCD presses into a 16-bit password word.
// Build option PASS_ENTRY_MASK_EN: display shows a dash (4'hA) for each held digit instead of its value.
module pass_entry_encoder #(
    parameter int NUM_DIGITS     = 4,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        key_enter,
    input  logic        key_clear,
    input  logic        key_back,
    output logic [15:0] pass_out,
    output logic        pass_valid,
    output logic        entry_err,
    output logic [2:0]  digit_cnt,
    output logic [15:0] disp_out
);

    localparam int          TIMER_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [2:0]  FULL_CNT   = 3'(NUM_DIGITS);
    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [31:0] TIMER_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

`ifdef PASS_ENTRY_MASK_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_FULL,
        ST_DONE
    } state_t;

    state_t               state_reg, state_next;
    logic [15:0]          buffer_reg, buffer_next;
    logic [2:0]           cnt_reg, cnt_next;
    logic [TIMER_W-1:0]   timer_reg, timer_next;
    logic [15:0]          pass_reg, pass_next;
    logic                 pass_valid_reg, pass_valid_next;
    logic                 err_reg, err_next;
    logic [15:0]          disp_reg, disp_next;

    logic                 accepted;
    logic [31:0]          timer_wide;
    logic                 timer_hit;

    assign timer_wide = 32'(timer_reg) + 32'd1;
    assign timer_hit  = (timer_wide >= TIMER_LAST);

    // Event decode in priority order: clear > enter > back > digit.
    always_comb begin
        state_next      = state_reg;
        buffer_next     = buffer_reg;
        cnt_next        = cnt_reg;
        timer_next      = timer_reg;
        pass_next       = pass_reg;
        pass_valid_next = 1'b0;
        err_next        = 1'b0;
        accepted        = 1'b0;

        if (state_reg == ST_DONE) begin
            // Submit cycle: every strobe is swallowed, entry already empty.
            state_next  = ST_IDLE;
            buffer_next = 16'h0000;
            cnt_next    = 3'd0;
            timer_next  = '0;
        end else begin
            if (key_clear) begin
                buffer_next = 16'h0000;
                cnt_next    = 3'd0;
                accepted    = 1'b1;
            end else if (key_enter) begin
                buffer_next = 16'h0000;
                cnt_next    = 3'd0;
                accepted    = 1'b1;
                if (cnt_reg == FULL_CNT) begin
                    pass_next       = buffer_reg;
                    pass_valid_next = 1'b1;
                end else begin
                    err_next = 1'b1;
                end
            end else if (key_back) begin
                if (cnt_reg != 3'd0) begin
                    buffer_next = {4'h0, buffer_reg[15:4]};
                    cnt_next    = cnt_reg - 3'd1;
                    accepted    = 1'b1;
                end
            end else if (key_valid) begin
                if ((key_code > 4'd9) || (cnt_reg == FULL_CNT)) begin
                    err_next = 1'b1;
                end else begin
                    buffer_next = {buffer_reg[11:0], key_code};
                    cnt_next    = cnt_reg + 3'd1;
                    accepted    = 1'b1;
                end
            end

            // Idle timer only runs while a partial entry is held and nothing was accepted.
            if (accepted || (cnt_reg == 3'd0) || !TIMEOUT_EN) begin
                timer_next = '0;
            end else if (timer_hit) begin
                buffer_next = 16'h0000;
                cnt_next    = 3'd0;
                err_next    = 1'b1;
                timer_next  = '0;
            end else begin
                timer_next = TIMER_W'(timer_wide);
            end

            if (pass_valid_next) begin
                state_next = ST_DONE;
            end else if (cnt_next == 3'd0) begin
                state_next = ST_IDLE;
            end else if (cnt_next == FULL_CNT) begin
                state_next = ST_FULL;
            end else begin
                state_next = ST_ENTRY;
            end
        end
    end

    // Display nibble gi is the gi-th newest held digit, blank (4'hF) when not held.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_disp
            assign disp_next[4*gi +: 4] = (3'(gi) < cnt_next)
                                        ? (MASK_EN ? 4'hA : buffer_next[4*gi +: 4])
                                        : 4'hF;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            buffer_reg     <= 16'h0000;
            cnt_reg        <= 3'd0;
            timer_reg      <= '0;
            pass_reg       <= 16'h0000;
            pass_valid_reg <= 1'b0;
            err_reg        <= 1'b0;
            disp_reg       <= 16'hFFFF;
        end else begin
            state_reg      <= state_next;
            buffer_reg     <= buffer_next;
            cnt_reg        <= cnt_next;
            timer_reg      <= timer_next;
            pass_reg       <= pass_next;
            pass_valid_reg <= pass_valid_next;
            err_reg        <= err_next;
            disp_reg       <= disp_next;
        end
    end

    assign pass_out   = pass_reg;
    assign pass_valid = pass_valid_reg;
    assign entry_err  = err_reg;
    assign digit_cnt  = cnt_reg;
    assign disp_out   = disp_reg;

endmodule

// File: tb/tb_pass_entry_encoder.sv
// Bench for pass_entry_encoder: directed keypad sequences then random strobes, all checked
// against a digit-queue reference model every cycle.
module tb_pass_entry_encoder;

    localparam int TO = 16;

`ifdef PASS_ENTRY_MASK_EN
    localparam bit MASKED = 1'b1;
`else
    localparam bit MASKED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_enter;
    logic        key_clear;
    logic        key_back;
    logic [15:0] pass_out;
    logic        pass_valid;
    logic        entry_err;
    logic [2:0]  digit_cnt;
    logic [15:0] disp_out;

    pass_entry_encoder #(
        .NUM_DIGITS    (4),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_enter (key_enter),
        .key_clear (key_clear),
        .key_back  (key_back),
        .pass_out  (pass_out),
        .pass_valid(pass_valid),
        .entry_err (entry_err),
        .digit_cnt (digit_cnt),
        .disp_out  (disp_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: held digits as a queue, oldest first.
    int          q[$];
    logic [15:0] m_pass;
    logic        m_valid;
    logic        m_err;
    int          idle;
    bit          in_done;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pack_q();
        logic [15:0] v = 16'h0;
        foreach (q[i]) v = v * 16 + 16'(q[i]);
        return v;
    endfunction

    function automatic logic [15:0] model_disp();
        logic [15:0] d;
        for (int i = 0; i < 4; i++) begin
            if (i < q.size()) d[4*i +: 4] = MASKED ? 4'hA : 4'(q[q.size() - 1 - i]);
            else              d[4*i +: 4] = 4'hF;
        end
        return d;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pass  = 16'h0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        idle    = 0;
        in_done = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [3:0] c, input logic e,
                              input logic cl, input logic b);
        bit acc = 1'b0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (in_done) begin
            in_done = 1'b0;
            return;
        end
        if (cl) begin
            q.delete(); acc = 1'b1;
        end else if (e) begin
            if (q.size() == 4) begin
                m_pass = pack_q(); m_valid = 1'b1; in_done = 1'b1;
            end else begin
                m_err = 1'b1;
            end
            q.delete(); acc = 1'b1;
        end else if (b) begin
            if (q.size() > 0) begin
                void'(q.pop_back()); acc = 1'b1;
            end
        end else if (v) begin
            if (c > 9 || q.size() == 4) m_err = 1'b1;
            else begin
                q.push_back(int'(c)); acc = 1'b1;
            end
        end
        if (acc || q.size() == 0) idle = 0;
        else begin
            idle++;
            if (idle >= TO - 1) begin
                q.delete(); m_err = 1'b1; idle = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("pass_out",   pass_out, m_pass);
        check("pass_valid", 16'(pass_valid), 16'(m_valid));
        check("entry_err",  16'(entry_err), 16'(m_err));
        check("digit_cnt",  16'(digit_cnt), 16'(q.size()));
        check("disp_out",   disp_out, model_disp());
    endtask

    // One clock: drive strobes, update the model at the edge, compare 1 time unit later.
    task automatic step(input logic v, input logic [3:0] c, input logic e,
                        input logic cl, input logic b);
        key_valid = v; key_code = c; key_enter = e; key_clear = cl; key_back = b;
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge(v, c, e, cl, b);
        #1;
        compare_all();
        key_valid = 1'b0; key_code = 4'h0; key_enter = 1'b0; key_clear = 1'b0; key_back = 1'b0;
    endtask

    task automatic digit(input logic [3:0] c);
        step(1'b1, c, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle_step();
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int r;
        logic [3:0] code;
        rst_n = 1'b0;
        key_valid = 1'b0; key_code = 4'h0; key_enter = 1'b0; key_clear = 1'b0; key_back = 1'b0;
        model_reset();
        idle_step();
        idle_step();
        check("rst_disp", disp_out, 16'hFFFF);
        rst_n = 1'b1;
        idle_step();

        // Full entry and submit.
        digit(4'd1); digit(4'd2); digit(4'd3); digit(4'd4);
        check("full_disp", MASKED ? 16'hAAAA : disp_out, MASKED ? disp_out : 16'h1234);
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        check("submit_word", pass_out, 16'h1234);
        check("submit_strobe", 16'(pass_valid), 16'd1);
        check("submit_cnt", 16'(digit_cnt), 16'd0);
        digit(4'd7);                                  // dropped during DONE
        check("done_drop_cnt", 16'(digit_cnt), 16'd0);
        check("strobe_one_cycle", 16'(pass_valid), 16'd0);
        check("pass_hold", pass_out, 16'h1234);

        // Backspace and short enter.
        digit(4'd5); digit(4'd6);
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        digit(4'd7);
        if (!MASKED) check("back_disp", disp_out, 16'hFF57);
        check("back_cnt", 16'(digit_cnt), 16'd2);
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        check("short_enter_err", 16'(entry_err), 16'd1);
        check("short_enter_valid", 16'(pass_valid), 16'd0);

        // Overflow and illegal code.
        digit(4'd9); digit(4'd8); digit(4'd7); digit(4'd6); digit(4'd5);
        check("overflow_err", 16'(entry_err), 16'd1);
        check("overflow_cnt", 16'(digit_cnt), 16'd4);
        digit(4'hC);
        check("bad_code_err", 16'(entry_err), 16'd1);

        // Clear beats enter.
        step(1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        check("clr_enter_valid", 16'(pass_valid), 16'd0);
        check("clr_enter_err", 16'(entry_err), 16'd0);
        check("clr_enter_word", pass_out, 16'h1234);

        // Idle timeout on a single held digit.
        digit(4'd3);
        for (int k = 1; k < TO - 1; k++) idle_step();
        check("pre_tmo_err", 16'(entry_err), 16'd0);
        idle_step();
        check("tmo_err", 16'(entry_err), 16'd1);
        check("tmo_cnt", 16'(digit_cnt), 16'd0);

        // Reset in the middle of an entry.
        digit(4'd3); digit(4'd1);
        if (MASKED) check("mask_disp", disp_out, 16'hFFAA);
        rst_n = 1'b0;
        digit(4'd2);
        check("mid_rst_disp", disp_out, 16'hFFFF);
        check("mid_rst_cnt", 16'(digit_cnt), 16'd0);
        rst_n = 1'b1;

        // Random strobes.
        for (int n = 0; n < 800; n++) begin
            r    = $urandom_range(0, 99);
            code = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            rst_n = (r == 99) ? 1'b0 : 1'b1;
            if (r < 45)      digit(code);
            else if (r < 55) step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
            else if (r < 59) step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
            else if (r < 67) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
            else if (r < 73) step(1'($urandom_range(0, 1)), code, 1'($urandom_range(0, 1)),
                                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else             idle_step();
        end
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
